// File: rtl/uart_stream_sender_pkg.sv
// rtl/uart_stream_sender_pkg.sv - shared encodings for the UART stream sender
package uart_stream_sender_pkg;

    // Handshake/frame FSM states (3-bit encoding)
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_REQUEST    = 3'd1,
        ST_WAIT_VALID = 3'd2,
        ST_START_BIT  = 3'd3,
        ST_DATA_BITS  = 3'd4,
        ST_STOP_BIT   = 3'd5
    } senderState_t;

    localparam logic UART_IDLE  = 1'b1;
    localparam logic UART_START = 1'b0;
    localparam int   DATA_BITS  = 8;

    // Line level the TX register should present in the next cycle
    localparam logic [1:0] LINE_HIGH = 2'd0;
    localparam logic [1:0] LINE_LOW  = 2'd1;
    localparam logic [1:0] LINE_DATA = 2'd2;

endpackage

// File: rtl/uart_tx_core.sv
// rtl/uart_tx_core.sv - bit timer, shift register and registered TX line
module uart_tx_core
    import uart_stream_sender_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       ReadClock,
    input  logic       Reset,
    input  logic       load,
    input  logic [7:0] loadData,
    input  logic       run,
    input  logic       inData,
    input  logic [1:0] lineSel,
    output logic       txSerial,
    output logic       bitDone,
    output logic       lastBit
);

    localparam logic [15:0] LAST_TICK = 16'(CLKS_PER_BIT - 1);

    logic [15:0] bitTimer;
    logic [7:0]  shiftReg;
    logic [2:0]  bitIndex;
    logic        shiftNow;

    assign bitDone  = run && (bitTimer == LAST_TICK);
    assign lastBit  = (bitIndex == 3'(DATA_BITS - 1));
    assign shiftNow = inData && bitDone;

    // Bit timer restarts at every bit boundary and whenever no frame is running
    always_ff @(posedge ReadClock) begin
        if (Reset || load || !run || bitDone) begin
            bitTimer <= '0;
        end else begin
            bitTimer <= bitTimer + 16'd1;
        end
    end

    // Shift register and bit index: load at frame start, advance at data bit boundaries
    always_ff @(posedge ReadClock) begin
        if (Reset) begin
            shiftReg <= '0;
            bitIndex <= '0;
        end else if (load) begin
            shiftReg <= loadData;
            bitIndex <= '0;
        end else if (shiftNow) begin
            shiftReg <= shiftReg >> 1;
            bitIndex <= bitIndex + 3'd1;
        end
    end

    // Registered line driver; looks ahead to the post-shift LSB so each bit is glitch-free
    always_ff @(posedge ReadClock) begin
        if (Reset) begin
            txSerial <= UART_IDLE;
        end else begin
            case (lineSel)
                LINE_LOW:  txSerial <= UART_START;
                LINE_DATA: txSerial <= shiftNow ? shiftReg[1] : shiftReg[0];
                default:   txSerial <= UART_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_stream_sender.sv
// rtl/uart_stream_sender.sv - pulls bytes from the storage FIFO and sends them as 8N1 UART
module uart_stream_sender
    import uart_stream_sender_pkg::*;
#(
    parameter int CLKS_PER_BIT  = 868,
    parameter int VALID_TIMEOUT = 8,
    parameter int COUNT_WIDTH   = 16
) (
    input  logic                   ReadClock,
    input  logic                   Reset,
    input  logic [7:0]             DataIn,
    input  logic                   DataValid,
    input  logic                   DataReadyToSend,
    input  logic                   SendEnable,
    output logic                   ReadEnable,
    output logic                   TxSerial,
    output logic                   Busy,
    output logic [COUNT_WIDTH-1:0] BytesSent,
    input  logic                   ClearCount,
    output logic                   TimeoutError,
    output logic                   ProtocolError
);

    localparam logic [7:0]             TIMEOUT_LAST = 8'(VALID_TIMEOUT - 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX    = '1;

    senderState_t state;
    senderState_t nextState;
    logic [7:0]   timeoutCnt;
    logic         loadByte;
    logic         frameDone;
    logic         timeoutHit;
    logic [1:0]   lineSel;
    logic         coreRun;
    logic         coreInData;
    logic         bitDone;
    logic         lastBit;

    assign ReadEnable = (state == ST_REQUEST);
    assign Busy       = (state != ST_IDLE);
    assign coreRun    = (state == ST_START_BIT) || (state == ST_DATA_BITS) || (state == ST_STOP_BIT);
    assign coreInData = (state == ST_DATA_BITS);

    // State register
    always_ff @(posedge ReadClock) begin
        if (Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic plus the line level the TX core should present next cycle
    always_comb begin
        nextState  = state;
        loadByte   = 1'b0;
        frameDone  = 1'b0;
        timeoutHit = 1'b0;
        lineSel    = LINE_HIGH;
        case (state)
            ST_IDLE: begin
                if (SendEnable && DataReadyToSend) nextState = ST_REQUEST;
            end
            ST_REQUEST: begin
                nextState = ST_WAIT_VALID;
            end
            ST_WAIT_VALID: begin
                if (DataValid) begin
                    loadByte  = 1'b1;
                    nextState = ST_START_BIT;
                end else if (timeoutCnt == TIMEOUT_LAST) begin
                    timeoutHit = 1'b1;
                    nextState  = ST_IDLE;
                end
            end
            ST_START_BIT: begin
                if (bitDone) nextState = ST_DATA_BITS;
            end
            ST_DATA_BITS: begin
                if (bitDone && lastBit) nextState = ST_STOP_BIT;
            end
            ST_STOP_BIT: begin
                if (bitDone) begin
                    frameDone = 1'b1;
                    nextState = (SendEnable && DataReadyToSend) ? ST_REQUEST : ST_IDLE;
                end
            end
            default: begin
                nextState = ST_IDLE;
            end
        endcase
        case (nextState)
            ST_START_BIT: lineSel = LINE_LOW;
            ST_DATA_BITS: lineSel = LINE_DATA;
            default:      lineSel = LINE_HIGH;
        endcase
    end

    // DataValid wait counter: cleared on the read strobe, counts idle WAIT_VALID cycles
    always_ff @(posedge ReadClock) begin
        if (Reset || (state == ST_REQUEST)) begin
            timeoutCnt <= '0;
        end else if ((state == ST_WAIT_VALID) && !DataValid && !timeoutHit) begin
            timeoutCnt <= timeoutCnt + 8'd1;
        end
    end

    // Saturating byte counter; a clear beats a simultaneous increment
    always_ff @(posedge ReadClock) begin
        if (Reset || ClearCount) begin
            BytesSent <= '0;
        end else if (frameDone && (BytesSent != COUNT_MAX)) begin
            BytesSent <= BytesSent + 1'b1;
        end
    end

    // Sticky fault flags, cleared only by Reset
    always_ff @(posedge ReadClock) begin
        if (Reset) begin
            TimeoutError  <= 1'b0;
            ProtocolError <= 1'b0;
        end else begin
            if (timeoutHit) TimeoutError <= 1'b1;
            if (DataValid && (state != ST_WAIT_VALID)) ProtocolError <= 1'b1;
        end
    end

    uart_tx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) txCore (
        .ReadClock(ReadClock),
        .Reset    (Reset),
        .load     (loadByte),
        .loadData (DataIn),
        .run      (coreRun),
        .inData   (coreInData),
        .lineSel  (lineSel),
        .txSerial (TxSerial),
        .bitDone  (bitDone),
        .lastBit  (lastBit)
    );

endmodule

// File: tb/tb_uart_stream_sender.sv
// tb/tb_uart_stream_sender.sv - directed self-checking bench for uart_stream_sender
module tb_uart_stream_sender;

    logic        ReadClock = 1'b0;
    logic        Reset = 1'b1;
    logic [7:0]  DataIn = 8'h00;
    logic        DataValid = 1'b0;
    logic        DataReadyToSend = 1'b0;
    logic        SendEnable = 1'b0;
    logic        ReadEnable;
    logic        TxSerial;
    logic        Busy;
    logic [15:0] BytesSent;
    logic        ClearCount = 1'b0;
    logic        TimeoutError;
    logic        ProtocolError;

    int passCount = 0;
    int totalCount = 0;

    // FIFO model state: bench writes wrPtr/forceReady/injectReq, model owns the rest
    logic [7:0] fifoMem [16];
    int wrPtr = 0;
    int rdPtr = 0;
    int readCount = 0;
    int injectReq = 0;
    int injectAck = 0;
    logic forceReady = 1'b0;
    logic validPending = 1'b0;
    logic [7:0] pendingByte = 8'h00;

    uart_stream_sender #(
        .CLKS_PER_BIT (4),
        .VALID_TIMEOUT(8),
        .COUNT_WIDTH  (16)
    ) dut (
        .ReadClock      (ReadClock),
        .Reset          (Reset),
        .DataIn         (DataIn),
        .DataValid      (DataValid),
        .DataReadyToSend(DataReadyToSend),
        .SendEnable     (SendEnable),
        .ReadEnable     (ReadEnable),
        .TxSerial       (TxSerial),
        .Busy           (Busy),
        .BytesSent      (BytesSent),
        .ClearCount     (ClearCount),
        .TimeoutError   (TimeoutError),
        .ProtocolError  (ProtocolError)
    );

    always #5 ReadClock = ~ReadClock;

    // Storage FIFO model: DataValid one cycle after each ReadEnable, spurious pulses on request
    always @(negedge ReadClock) begin
        if (validPending) begin
            DataValid = 1'b1;
            DataIn = pendingByte;
            validPending = 1'b0;
        end else if (injectReq != injectAck) begin
            DataValid = 1'b1;
            DataIn = 8'hEE;
            injectAck = injectReq;
        end else begin
            DataValid = 1'b0;
        end
        if (ReadEnable === 1'b1) begin
            readCount++;
            if (wrPtr != rdPtr) begin
                pendingByte = fifoMem[rdPtr % 16];
                rdPtr++;
                validPending = 1'b1;
            end
        end
        DataReadyToSend = (wrPtr != rdPtr) || forceReady;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCount++;
        assert (obs === exp) begin
            passCount++;
        end else begin
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ReadClock);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        fifoMem[wrPtr % 16] = b;
        wrPtr++;
    endtask

    task automatic waitStart(input string tag);
        logic found;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (TxSerial === 1'b0) found = 1'b1;
            else step();
        end
        check(tag, 32'(found), 32'd1);
    endtask

    task automatic waitReadEnable(input string tag);
        logic found;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (ReadEnable === 1'b1) found = 1'b1;
            else step();
        end
        check(tag, 32'(found), 32'd1);
    endtask

    // Checks all 40 cycles of a frame starting at the first start-bit cycle
    task automatic checkFrame(input logic [7:0] b, input int dropAt, input int clearAt);
        int slot;
        logic expBit;
        for (int i = 0; i < 40; i++) begin
            slot = i / 4;
            if (slot == 0) expBit = 1'b0;
            else if (slot == 9) expBit = 1'b1;
            else expBit = b[slot - 1];
            check($sformatf("frame_%02h_cyc%0d", b, i), 32'(TxSerial), 32'(expBit));
            if (i == 39) check($sformatf("busy_last_stop_%02h", b), 32'(Busy), 32'd1);
            if (i == dropAt) SendEnable = 1'b0;
            if (i == clearAt) ClearCount = 1'b1;
            step();
            ClearCount = 1'b0;
        end
    endtask

    task automatic checkGap(input string tag);
        check({tag, "_gap0"}, 32'(TxSerial), 32'd1);
        step();
        check({tag, "_gap1"}, 32'(TxSerial), 32'd1);
        step();
    endtask

    initial begin
        int rc0;

        // Reset state
        Reset = 1'b1;
        step();
        step();
        check("rst_tx", 32'(TxSerial), 32'd1);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_re", 32'(ReadEnable), 32'd0);
        check("rst_count", 32'(BytesSent), 32'd0);
        check("rst_terr", 32'(TimeoutError), 32'd0);
        check("rst_perr", 32'(ProtocolError), 32'd0);
        Reset = 1'b0;
        step();

        // Single byte 0xA5
        SendEnable = 1'b1;
        push(8'hA5);
        waitStart("a5_start");
        checkFrame(8'hA5, -1, -1);
        check("a5_busy_after", 32'(Busy), 32'd0);
        check("a5_count", 32'(BytesSent), 32'd1);

        // Four back-to-back bytes with 2-cycle gaps
        ClearCount = 1'b1;
        step();
        ClearCount = 1'b0;
        check("clear_count", 32'(BytesSent), 32'd0);
        rc0 = readCount;
        push(8'hFF);
        push(8'h80);
        push(8'h7F);
        push(8'h00);
        waitStart("b2b_start");
        checkFrame(8'hFF, -1, -1);
        checkGap("b2b_1");
        checkFrame(8'h80, -1, -1);
        checkGap("b2b_2");
        checkFrame(8'h7F, -1, -1);
        checkGap("b2b_3");
        checkFrame(8'h00, -1, -1);
        check("b2b_busy_after", 32'(Busy), 32'd0);
        check("b2b_reads", 32'(readCount - rc0), 32'd4);
        check("b2b_count", 32'(BytesSent), 32'd4);

        // DataValid never returned: timeout after 8 WAIT_VALID cycles
        forceReady = 1'b1;
        waitReadEnable("to_request");
        SendEnable = 1'b0;
        forceReady = 1'b0;
        step();
        check("to_re_one_cycle", 32'(ReadEnable), 32'd0);
        for (int k = 0; k < 7; k++) step();
        check("to_err_wait8", 32'(TimeoutError), 32'd0);
        check("to_busy_wait8", 32'(Busy), 32'd1);
        check("to_tx_wait8", 32'(TxSerial), 32'd1);
        step();
        check("to_err", 32'(TimeoutError), 32'd1);
        check("to_busy", 32'(Busy), 32'd0);
        check("to_tx", 32'(TxSerial), 32'd1);
        check("to_count", 32'(BytesSent), 32'd4);

        // Reset during data bit 3 of 0x52
        SendEnable = 1'b1;
        push(8'h52);
        waitStart("rst_mid_start");
        for (int k = 0; k < 18; k++) step();
        check("rst_mid_bit3", 32'(TxSerial), 32'd0);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        check("rst_mid_tx", 32'(TxSerial), 32'd1);
        check("rst_mid_busy", 32'(Busy), 32'd0);
        check("rst_mid_count", 32'(BytesSent), 32'd0);
        check("rst_mid_terr", 32'(TimeoutError), 32'd0);
        push(8'hC3);
        waitStart("post_rst_start");
        checkFrame(8'hC3, -1, -1);
        check("post_rst_count", 32'(BytesSent), 32'd1);

        // SendEnable dropped mid-frame with three bytes queued
        rc0 = readCount;
        push(8'h11);
        push(8'h22);
        push(8'h33);
        waitStart("drop_start");
        checkFrame(8'h11, 10, -1);
        for (int k = 0; k < 20; k++) step();
        check("drop_reads", 32'(readCount - rc0), 32'd1);
        check("drop_busy", 32'(Busy), 32'd0);
        check("drop_tx", 32'(TxSerial), 32'd1);
        SendEnable = 1'b1;
        waitStart("resume_start");
        checkFrame(8'h22, -1, -1);
        checkGap("resume");
        checkFrame(8'h33, -1, -1);
        check("resume_count", 32'(BytesSent), 32'd4);
        check("resume_reads", 32'(readCount - rc0), 32'd3);
        check("resume_perr", 32'(ProtocolError), 32'd0);

        // Spurious DataValid while idle
        SendEnable = 1'b0;
        injectReq++;
        step();
        step();
        check("spur_perr", 32'(ProtocolError), 32'd1);
        check("spur_busy", 32'(Busy), 32'd0);
        check("spur_tx", 32'(TxSerial), 32'd1);
        step();
        check("spur_no_tx", 32'(Busy), 32'd0);

        // ClearCount on the stop-bit increment cycle wins
        SendEnable = 1'b1;
        push(8'h0F);
        waitStart("clr_start");
        checkFrame(8'h0F, -1, 39);
        check("clr_wins", 32'(BytesSent), 32'd0);
        check("clr_perr_sticky", 32'(ProtocolError), 32'd1);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
